// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with a status-tagged receive FIFO.
//
// Both PS/2 lines are synchronized and glitch-filtered. Falling edges of the
// filtered clock drive an IDLE/DATA/PARITY/STOP frame FSM. Each completed or
// aborted frame pushes {status, byte} into a FIFO with a ready/valid read side.
//
// Ports:
//   clock, reset_n   system clock (rising edge), asynchronous active-low reset
//   device_clock     PS/2 clock line (asynchronous)
//   device_data      PS/2 data line (asynchronous)
//   enable           receiver enable; low holds the FSM in IDLE
//   clear            one-cycle pulse: empty the FIFO and clear overflow_flag
//   rd_ready         consumer accepts the head entry
//   rd_valid         FIFO not empty
//   rd_data          head entry byte
//   rd_error         head entry status: 00 ok, 01 parity, 10 framing, 11 timeout
//   fifo_count       number of stored entries
//   overflow_flag    sticky: a frame was dropped because the FIFO was full
module ps2_rx_fifo #(
    parameter logic [15:0] OVER_TIME  = 16'd1000,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          device_clock,
    input  logic                          device_data,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic [1:0]                    rd_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_flag
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  FiltMax  = 4'(FILTER_LEN - 1);
    localparam logic [AW:0] FullCnt  = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Synchronizers and filters
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q, dat_sync_q;
    logic       clk_filt_q, dat_filt_q;
    logic [3:0] clk_cnt_q, dat_cnt_q;
    logic       clk_filt_prev_q;
    logic       fall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], device_clock};
            dat_sync_q <= {dat_sync_q[0], device_data};
        end
    end

    // A filtered line follows its synchronized input only after the input has
    // disagreed with it for FILTER_LEN consecutive cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q      <= 1'b1;
            dat_filt_q      <= 1'b1;
            clk_cnt_q       <= '0;
            dat_cnt_q       <= '0;
            clk_filt_prev_q <= 1'b1;
        end else begin
            clk_filt_prev_q <= clk_filt_q;

            if (clk_sync_q[1] == clk_filt_q) begin
                clk_cnt_q <= '0;
            end else if (clk_cnt_q == FiltMax) begin
                clk_filt_q <= clk_sync_q[1];
                clk_cnt_q  <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 4'd1;
            end

            if (dat_sync_q[1] == dat_filt_q) begin
                dat_cnt_q <= '0;
            end else if (dat_cnt_q == FiltMax) begin
                dat_filt_q <= dat_sync_q[1];
                dat_cnt_q  <= '0;
            end else begin
                dat_cnt_q <= dat_cnt_q + 4'd1;
            end
        end
    end

    assign fall = clk_filt_prev_q & ~clk_filt_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [15:0] timer_q, timer_d;
    logic        push;
    logic [9:0]  push_entry;
    logic [1:0]  stop_status;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timer_q   <= timer_d;
        end
    end

    // Framing error wins over parity; odd parity means byte+parity has odd weight.
    always_comb begin
        if (!dat_filt_q) begin
            stop_status = 2'b10;
        end else if (!(^{shift_q, parity_q})) begin
            stop_status = 2'b01;
        end else begin
            stop_status = 2'b00;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        timer_d    = timer_q;
        push       = 1'b0;
        push_entry = '0;

        if (!enable) begin
            state_d = StIdle;
            timer_d = '0;
        end else if (state_q == StIdle) begin
            timer_d = '0;
            if (fall && !dat_filt_q) begin
                state_d   = StData;
                bit_cnt_d = '0;
                shift_d   = '0;
            end
        end else if (fall) begin
            timer_d = '0;
            case (state_q)
                StData: begin
                    shift_d   = {dat_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = dat_filt_q;
                    state_d  = StStop;
                end
                StStop: begin
                    push       = 1'b1;
                    push_entry = {stop_status, shift_q};
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (timer_q >= OVER_TIME) begin
            // Stalled frame: report whatever has been shifted in so far.
            push       = 1'b1;
            push_entry = {2'b11, shift_q};
            state_d    = StIdle;
            timer_d    = '0;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          pop, full, push_ok;

    assign full    = (count_q == FullCnt);
    assign rd_valid = (count_q != '0);
    assign pop     = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Gate the head with rd_valid so an empty FIFO reads as zero.
    assign {rd_error, rd_data} = rd_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign fifo_count    = count_q;
    assign overflow_flag = ovf_q;

endmodule
